// File: rtl/seq_word_ctrl.sv
// Word-level sequencer for a bit-serial Mealy detector: loads a word, shifts it MSB-first into
// the detector, counts hit cycles and returns the result. Optional SEQ_WORD_CTRL_FIRST_POS_EN adds res_first.
module seq_word_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_count,
  output logic             res_any,
`ifdef SEQ_WORD_CTRL_FIRST_POS_EN
  output logic [CNT_W-1:0] res_first,
`endif
  output logic             det_rst,
  output logic             det_data,
  input  logic             det_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] shreg_r;
  logic [CNT_W-1:0] bitcnt_r;
  logic [CNT_W-1:0] count_r;
  logic             accept_s;
  logic             last_bit_s;

  assign accept_s   = in_valid & in_ready;
  assign last_bit_s = (bitcnt_r == CNT_W'(WIDTH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = SHIFT;
        else          state_s = IDLE;
      end
      SHIFT: begin
        if (last_bit_s) state_s = DONE;
        else            state_s = SHIFT;
      end
      DONE: begin
        if (res_ready) state_s = IDLE;
        else           state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Output decode from registered state; detector is held in reset outside SHIFT
  always_comb begin
    in_ready  = 1'b0;
    res_valid = 1'b0;
    det_rst   = 1'b1;
    det_data  = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready = 1'b1;
      end
      SHIFT: begin
        det_rst  = 1'b0;
        det_data = shreg_r[WIDTH-1];
      end
      DONE: begin
        res_valid = 1'b1;
      end
      default: begin
        in_ready  = 1'b0;
        res_valid = 1'b0;
      end
    endcase
  end

  // Shift register, bit counter and hit counter
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_r  <= {WIDTH{1'b0}};
      bitcnt_r <= {CNT_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (state_r == IDLE && accept_s) begin
      shreg_r  <= in_data;
      bitcnt_r <= {CNT_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (state_r == SHIFT) begin
      shreg_r  <= {shreg_r[WIDTH-2:0], 1'b0};
      bitcnt_r <= bitcnt_r + CNT_W'(1);
      if (det_out) count_r <= count_r + CNT_W'(1);
    end
  end

  assign res_count = count_r;
  assign res_any   = (count_r != {CNT_W{1'b0}});

`ifdef SEQ_WORD_CTRL_FIRST_POS_EN
  logic [CNT_W-1:0] first_r;

  // First-hit index; WIDTH doubles as the "no hit yet" marker since bitcnt never reaches it in SHIFT
  always_ff @(posedge clk) begin
    if (rst) begin
      first_r <= CNT_W'(WIDTH);
    end else if (state_r == IDLE && accept_s) begin
      first_r <= CNT_W'(WIDTH);
    end else if (state_r == SHIFT && det_out && first_r == CNT_W'(WIDTH)) begin
      first_r <= bitcnt_r;
    end
  end

  assign res_first = first_r;
`endif

endmodule

// File: tb/tb_seq_word_ctrl.sv
// Directed bench for seq_word_ctrl (WIDTH=8) with a stub detector that echoes det_data while enabled.
module tb_seq_word_ctrl;
  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             res_valid;
  logic             res_ready;
  logic [CNT_W-1:0] res_count;
  logic             res_any;
`ifdef SEQ_WORD_CTRL_FIRST_POS_EN
  logic [CNT_W-1:0] res_first;
`endif
  logic             det_rst;
  logic             det_data;
  logic             det_out;

  int n_asserts = 0;
  int n_fail    = 0;
  time t_prev;
  time t_acc;

  always #5 clk = ~clk;

  assign det_out = det_rst ? 1'b0 : det_data;

  seq_word_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_count(res_count), .res_any(res_any),
`ifdef SEQ_WORD_CTRL_FIRST_POS_EN
    .res_first(res_first),
`endif
    .det_rst(det_rst), .det_data(det_data), .det_out(det_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a word, wait (bounded) for acceptance, check every serial bit, end in DONE.
  task automatic start_word(input logic [WIDTH-1:0] d);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && guard < 20) begin
      tick();
      guard++;
    end
    chk("accept_ready", 32'(in_ready), 32'd1);
    tick();
    t_acc    = $time;
    in_valid = 1'b0;
    chk("shift_det_rst", 32'(det_rst), 32'd0);
    chk("shift_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < WIDTH; i++) begin
      chk("bit", 32'(det_data), 32'(d[WIDTH-1-i]));
      if (i == WIDTH - 1) chk("no_early_valid", 32'(res_valid), 32'd0);
      tick();
    end
    chk("res_valid", 32'(res_valid), 32'd1);
    chk("done_det_rst", 32'(det_rst), 32'd1);
  endtask

  task automatic check_result(input int cnt, input int first);
    chk("res_count", 32'(res_count), 32'(cnt));
    chk("res_any", 32'(res_any), (cnt != 0) ? 32'd1 : 32'd0);
`ifdef SEQ_WORD_CTRL_FIRST_POS_EN
    chk("res_first", 32'(res_first), 32'(first));
`else
    if (first < 0) $display("unexpected first index %0d", first);
`endif
  endtask

  task automatic release_result();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("back_idle", 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; res_ready = 1'b0;
    t_prev = 0; t_acc = 0;

    // 1: reset
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_det_rst", 32'(det_rst), 32'd1);
    chk("rst_det_data", 32'(det_data), 32'd0);
    chk("rst_res_count", 32'(res_count), 32'd0);
    chk("rst_res_any", 32'(res_any), 32'd0);

    // 2: 0xA5
    start_word(8'hA5);
    check_result(4, 0);
    release_result();

    // 3: 0x00 and 0xFF
    start_word(8'h00);
    check_result(0, 8);
    release_result();
    start_word(8'hFF);
    check_result(8, 0);
    release_result();

    // 4: stall in DONE with a competing word offered
    start_word(8'h3C);
    in_valid = 1'b1;
    in_data  = 8'h81;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", 32'(res_valid), 32'd1);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      check_result(4, 2);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("stall_idle", 32'(in_ready), 32'd1);
    chk("stall_idle_valid", 32'(res_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    chk("stall_next_accept", 32'(det_rst), 32'd0);
    chk("stall_next_bit", 32'(det_data), 32'd1);
    for (int i = 0; i < WIDTH; i++) tick();
    check_result(2, 0);
    release_result();

    // 5: reset during bit 4 of 0xF0, then 0x03
    in_valid = 1'b1;
    in_data  = 8'hF0;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("abort_mid_shift", 32'(det_rst), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_res_valid", 32'(res_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_det_rst", 32'(det_rst), 32'd1);
    chk("abort_res_count", 32'(res_count), 32'd0);
    start_word(8'h03);
    check_result(2, 6);
    release_result();

    // 6: back-to-back 0x81, 0x18
    start_word(8'h81);
    t_prev = t_acc;
    check_result(2, 0);
    release_result();
    start_word(8'h18);
    chk("spacing", 32'(t_acc - t_prev), 32'd100);
    check_result(2, 3);
    release_result();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
